// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with wrap or saturate ends, binary or
// Gray-coded load, combinational terminal count and a registered wrap pulse.
module gray_counter_n #(
    parameter int WIDTH     = 4,
    parameter int WRAP      = 1,
    parameter int LOAD_GRAY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] load_val;
    logic             at_max, at_zero;

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign load_bin[gi] = ^data_in[WIDTH-1:gi];
        end
    endgenerate

    assign load_val = (LOAD_GRAY != 0) ? load_bin : data_in;
    assign at_max   = (cnt_q == MAX);
    assign at_zero  = (cnt_q == ZERO);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load_en) begin
            cnt_d = load_val;
        end else if (en) begin
            if (up_dn) begin
                if (!at_max) begin
                    cnt_d = cnt_q + ONE;
                end else if (WRAP != 0) begin
                    cnt_d  = ZERO;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    cnt_d = cnt_q - ONE;
                end else if (WRAP != 0) begin
                    cnt_d  = MAX;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // Gray view is registered from the same next value so both views always agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= ZERO;
            gray_q <= ZERO;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= cnt_d ^ (cnt_d >> 1);
            wrap_q <= wrap_d;
        end
    end

    assign tc       = en & ~load_en & ((up_dn & at_max) | (~up_dn & at_zero));
    assign bin_out  = cnt_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: three parameterisations driven in lockstep,
// expectations from an integer reference model, checked by a separate monitor.
module tb_gray_counter_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load_en = 1'b0;
    logic [5:0] data_in = '0;

    logic [3:0] g0, b0, g1, b1;
    logic [5:0] g2, b2;
    logic [2:0] a_tc, a_wrap;
    logic [2:0][5:0] a_bin, a_gray;

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(4), .WRAP(1), .LOAD_GRAY(0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load_en(load_en),
        .data_in(data_in[3:0]), .gray_out(g0), .bin_out(b0), .tc(a_tc[0]), .wrap(a_wrap[0]));
    gray_counter_n #(.WIDTH(4), .WRAP(0), .LOAD_GRAY(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load_en(load_en),
        .data_in(data_in[3:0]), .gray_out(g1), .bin_out(b1), .tc(a_tc[1]), .wrap(a_wrap[1]));
    gray_counter_n #(.WIDTH(6), .WRAP(1), .LOAD_GRAY(1)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load_en(load_en),
        .data_in(data_in), .gray_out(g2), .bin_out(b2), .tc(a_tc[2]), .wrap(a_wrap[2]));

    assign a_bin[0]  = {2'b00, b0};
    assign a_bin[1]  = {2'b00, b1};
    assign a_bin[2]  = b2;
    assign a_gray[0] = {2'b00, g0};
    assign a_gray[1] = {2'b00, g1};
    assign a_gray[2] = g2;

    typedef struct packed {
        logic [2:0]      tc;
        logic [2:0]      wrap;
        logic [2:0]      onebit;
        logic [2:0][5:0] bin;
        logic [2:0][5:0] gray;
    } exp_t;

    exp_t sb_q[$];
    int   m_cnt[3];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic int pw(int k);
        return (k == 2) ? 6 : 4;
    endfunction
    function automatic bit pwrap(int k);
        return k != 1;
    endfunction
    function automatic bit pgray(int k);
        return k != 0;
    endfunction

    // Binary value whose Gray code equals g: found by searching the code table.
    function automatic int gray_index(int g, int mx);
        for (int n = 0; n <= mx; n++)
            if ((n ^ (n >> 1)) == g) return n;
        return -1;
    endfunction

    function automatic void chk(string nm, int k, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endfunction

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input logic [5:0] d);
        exp_t x;
        int   mx, c, nc;
        bit   w;
        @(negedge clk);
        reset = r; en = e; up_dn = u; load_en = l; data_in = d;
        x = '0;
        for (int k = 0; k < 3; k++) begin
            mx = (1 << pw(k)) - 1;
            c  = m_cnt[k];
            nc = c;
            w  = 1'b0;
            x.tc[k] = e && !l && ((u && c == mx) || (!u && c == 0));
            if (r) nc = 0;
            else if (l) nc = pgray(k) ? gray_index(int'(d) & mx, mx) : (int'(d) & mx);
            else if (e) begin
                if (u) begin
                    if (c < mx) nc = c + 1;
                    else if (pwrap(k)) begin nc = 0; w = 1'b1; end
                end else begin
                    if (c > 0) nc = c - 1;
                    else if (pwrap(k)) begin nc = mx; w = 1'b1; end
                end
            end
            x.onebit[k] = !r && !l && e && (nc != c);
            m_cnt[k]    = nc;
            x.wrap[k]   = w;
            x.bin[k]    = 6'(nc);
            x.gray[k]   = 6'(nc ^ (nc >> 1));
        end
        sb_q.push_back(x);
    endtask

    // Monitor: tc is sampled mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t       x;
        logic [5:0] prev_gray [3];
        for (int k = 0; k < 3; k++) prev_gray[k] = '0;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                for (int k = 0; k < 3; k++) chk("tc", k, int'(a_tc[k]), int'(x.tc[k]));
                @(posedge clk);
                #1;
                for (int k = 0; k < 3; k++) begin
                    chk("bin_out", k, int'(a_bin[k]), int'(x.bin[k]));
                    chk("gray_out", k, int'(a_gray[k]), int'(x.gray[k]));
                    chk("wrap", k, int'(a_wrap[k]), int'(x.wrap[k]));
                    if (x.onebit[k])
                        chk("gray_one_bit_step", k, $countones(prev_gray[k] ^ a_gray[k]), 1);
                    prev_gray[k] = a_gray[k];
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        repeat (2) drive(1, 0, 1, 0, 6'd0);
        repeat (17) drive(0, 1, 1, 0, 6'd0);
        drive(0, 1, 1, 1, 6'b001001);
        repeat (2) drive(0, 1, 1, 0, 6'd0);
        drive(0, 0, 0, 1, 6'b001101);
        repeat (2) drive(0, 1, 0, 0, 6'd0);
        drive(0, 0, 1, 1, 6'b001110);
        repeat (3) drive(0, 1, 1, 0, 6'd0);
        drive(0, 0, 1, 1, 6'b000101);
        drive(1, 1, 1, 1, 6'b000101);
        repeat (3) drive(0, 0, 1, 0, 6'd0);
        repeat (3) drive(0, 1, 0, 0, 6'd0);
        drive(0, 0, 1, 1, 6'b000000);
        repeat (66) drive(0, 1, 0, 0, 6'd0);
        for (int i = 0; i < 400; i++)
            drive($urandom_range(31) == 0, $urandom_range(3) != 0, 1'($urandom),
                  $urandom_range(7) == 0, 6'($urandom));
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
